// File: rtl/decoder_rr_arbiter_if.sv
// Request/grant bundle between requesters (master) and the decoder arbiter (slave).
interface decoder_rr_arbiter_if;
    logic [7:0] req;
    logic [2:0] grant_idx;
    logic       grant_en;
    logic [7:0] grant_onehot;
    logic       busy;

    modport master (output req, input grant_idx, grant_en, grant_onehot, busy);
    modport slave  (input req, output grant_idx, grant_en, grant_onehot, busy);
endinterface

// File: rtl/decoder_rr_arbiter.sv
// Round-robin arbiter driving a shared enable-gated 3-to-8 decoder, with bounded hold.
// Optional ARB_TURNAROUND_EN inserts one dead GAP cycle after every release.
module decoder_rr_arbiter #(
    parameter int MAX_HOLD = 4,
    parameter int CNT_W    = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    decoder_rr_arbiter_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE,
        GRANT
`ifdef ARB_TURNAROUND_EN
        , GAP
`endif
    } state_t;

    state_t           state;
    logic [2:0]       grant_idx;
    logic             grant_en;
    logic [2:0]       last_idx;
    logic [CNT_W-1:0] hold_cnt;

    logic             win_vld;
    logic [2:0]       win_idx;
    logic             release_now;

    // Search starts just past the last winner; the base itself is checked last,
    // so a sole requester that timed out is picked again.
    always_comb begin
        logic [2:0] cand;
        win_vld = 1'b0;
        win_idx = '0;
        cand    = '0;
        for (int k = 1; k <= 8; k++) begin
            cand = last_idx + 3'(k);
            if (!win_vld && bus.req[cand]) begin
                win_vld = 1'b1;
                win_idx = cand;
            end
        end
    end

    // A drop and a timeout in the same cycle collapse into one release.
    assign release_now = !bus.req[grant_idx] || (hold_cnt == CNT_W'(MAX_HOLD - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            grant_idx <= '0;
            grant_en  <= 1'b0;
            last_idx  <= 3'd7;
            hold_cnt  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (win_vld) begin
                        state     <= GRANT;
                        grant_idx <= win_idx;
                        grant_en  <= 1'b1;
                        last_idx  <= win_idx;
                        hold_cnt  <= '0;
                    end
                end
                GRANT: begin
                    if (release_now) begin
`ifdef ARB_TURNAROUND_EN
                        state    <= GAP;
                        grant_en <= 1'b0;
`else
                        if (win_vld) begin
                            grant_idx <= win_idx;
                            last_idx  <= win_idx;
                            hold_cnt  <= '0;
                        end else begin
                            state    <= IDLE;
                            grant_en <= 1'b0;
                        end
`endif
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
`ifdef ARB_TURNAROUND_EN
                GAP: begin
                    if (win_vld) begin
                        state     <= GRANT;
                        grant_idx <= win_idx;
                        grant_en  <= 1'b1;
                        last_idx  <= win_idx;
                        hold_cnt  <= '0;
                    end else begin
                        state <= IDLE;
                    end
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end

    for (genvar g = 0; g < 8; g++) begin : g_dec
        assign bus.grant_onehot[g] = grant_en && (grant_idx == 3'(g));
    end

    assign bus.grant_idx = grant_idx;
    assign bus.grant_en  = grant_en;
    assign bus.busy      = (state != IDLE);

endmodule

// File: tb/tb_decoder_rr_arbiter.sv
// Bench for decoder_rr_arbiter: two instances (MAX_HOLD 4 and 1) against a cycle-level reference.
module tb_decoder_rr_arbiter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    decoder_rr_arbiter_if bus4 ();
    decoder_rr_arbiter_if bus1 ();

    decoder_rr_arbiter #(.MAX_HOLD(4), .CNT_W(4)) u4 (.clk(clk), .rst_n(rst_n), .bus(bus4));
    decoder_rr_arbiter #(.MAX_HOLD(1), .CNT_W(4)) u1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

    int n_chk = 0;
    int n_fail = 0;

    // reference model: [0] -> MAX_HOLD 4, [1] -> MAX_HOLD 1
    int m_maxh [2] = '{4, 1};
    int m_idx  [2];
    int m_en   [2];
    int m_last [2];
    int m_cnt  [2];
    int m_gap  [2];

    function automatic int pick(input logic [7:0] r, input int base);
        for (int k = 1; k <= 8; k++)
            if (r[(base + k) % 8]) return (base + k) % 8;
        return -1;
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_idx[d] = 0; m_en[d] = 0; m_last[d] = 7; m_cnt[d] = 0; m_gap[d] = 0;
        end
    endtask

    task automatic model_take(input int d, input int w);
        m_idx[d] = w; m_en[d] = 1; m_last[d] = w; m_cnt[d] = 0;
    endtask

    task automatic model_step(input logic [7:0] r);
        int w;
        for (int d = 0; d < 2; d++) begin
            if (m_gap[d] != 0) begin
                m_gap[d] = 0;
                w = pick(r, m_last[d]);
                if (w >= 0) model_take(d, w);
            end else if (m_en[d] == 0) begin
                w = pick(r, m_last[d]);
                if (w >= 0) model_take(d, w);
            end else if (!r[m_idx[d]] || m_cnt[d] == m_maxh[d] - 1) begin
`ifdef ARB_TURNAROUND_EN
                m_en[d] = 0;
                m_gap[d] = 1;
`else
                w = pick(r, m_idx[d]);
                if (w >= 0) model_take(d, w);
                else m_en[d] = 0;
`endif
            end else begin
                m_cnt[d]++;
            end
        end
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string where);
        logic [7:0] oh;
        for (int d = 0; d < 2; d++) begin
            oh = (m_en[d] != 0) ? (8'h01 << m_idx[d]) : 8'h00;
            if (d == 0) begin
                check($sformatf("%s.h4.en", where),  {7'b0, bus4.grant_en}, 8'(m_en[d]));
                check($sformatf("%s.h4.idx", where), {5'b0, bus4.grant_idx}, 8'(m_idx[d]));
                check($sformatf("%s.h4.oh", where),  bus4.grant_onehot, oh);
                check($sformatf("%s.h4.busy", where), {7'b0, bus4.busy}, 8'((m_en[d] != 0) || (m_gap[d] != 0)));
            end else begin
                check($sformatf("%s.h1.en", where),  {7'b0, bus1.grant_en}, 8'(m_en[d]));
                check($sformatf("%s.h1.idx", where), {5'b0, bus1.grant_idx}, 8'(m_idx[d]));
                check($sformatf("%s.h1.oh", where),  bus1.grant_onehot, oh);
                check($sformatf("%s.h1.busy", where), {7'b0, bus1.busy}, 8'((m_en[d] != 0) || (m_gap[d] != 0)));
            end
        end
    endtask

    task automatic step(input logic [7:0] r, input string where);
        @(negedge clk);
        bus4.req = r;
        bus1.req = r;
        @(posedge clk);
        model_step(r);
        #1;
        check_all(where);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        bus4.req = 8'h00;
        bus1.req = 8'h00;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        bus4.req = 8'h00;
        bus1.req = 8'h00;
        model_reset();
        #2;
        check_all("reset");
        do_reset();

        // idle with no requests
        for (int i = 0; i < 5; i++) step(8'h00, "idle");
        check("idle.busy", {7'b0, bus4.busy}, 8'h00);

        // single requester held: grant after one edge, timeout re-grants itself
        step(8'h04, "solo");
        check("solo.first_idx", {5'b0, bus4.grant_idx}, 8'h02);
        check("solo.first_oh", bus4.grant_onehot, 8'h04);
        for (int i = 0; i < 9; i++) step(8'h04, "solo");
`ifndef ARB_TURNAROUND_EN
        check("solo.en_stays", {7'b0, bus4.grant_en}, 8'h01);
`endif

        // full load: MAX_HOLD=1 instance rotates
        do_reset();
        for (int i = 0; i < 9; i++) begin
            step(8'hFF, "full");
`ifndef ARB_TURNAROUND_EN
            check("full.walk", bus1.grant_onehot, 8'h01 << (i % 8));
`endif
        end

        // owner 3 drops while 6 and 1 request: next is 6, then 1
        do_reset();
        step(8'h08, "drop");
        step(8'h4A, "drop");
        step(8'h42, "drop");
        step(8'h42, "drop");
`ifndef ARB_TURNAROUND_EN
        check("drop.next6", {5'b0, bus4.grant_idx}, 8'h06);
`endif
        for (int i = 0; i < 6; i++) step(8'h42, "drop");
        step(8'h81, "pair");
        for (int i = 0; i < 10; i++) step(8'h81, "pair");

        // async reset in the middle of a grant on idx 5
        do_reset();
        step(8'h20, "pre_rst");
        step(8'h20, "pre_rst");
        check("pre_rst.idx5", {5'b0, bus4.grant_idx}, 8'h05);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst.en",   {7'b0, bus4.grant_en}, 8'h00);
        check("rst.busy", {7'b0, bus4.busy}, 8'h00);
        check("rst.oh",   bus4.grant_onehot, 8'h00);
        check("rst.idx",  {5'b0, bus4.grant_idx}, 8'h00);
        model_reset();
        @(negedge clk);
        bus4.req = 8'h00;
        bus1.req = 8'h00;
        @(negedge clk);
        rst_n = 1'b1;
        step(8'h21, "post_rst");
        check("post_rst.idx0", {5'b0, bus4.grant_idx}, 8'h00);
        for (int i = 0; i < 6; i++) step(8'h21, "post_rst");

        // randomized traffic of varying density
        for (int i = 0; i < 400; i++) begin
            logic [7:0] r;
            r = 8'($urandom);
            case (i / 100)
                0: r = r & 8'($urandom);
                1: r = r | 8'($urandom);
                2: r = (($urandom_range(0, 3) == 0) ? 8'h00 : r);
                default: ;
            endcase
            step(r, "rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not reach end");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/decoder_rr_arbiter.md
Name: decoder_rr_arbiter

Overview:
- Round-robin arbiter sharing one 3-to-8 enable-gated decoder (chip-select style one-hot output) among 8 requesters.
- Produces the registered 3-bit select index plus enable that drive the decoder.
- Also exposes the decoded one-hot grant for local use.
- Bounds each ownership to MAX_HOLD cycles so no requester starves.

Parameters:
- MAX_HOLD, 4, maximum consecutive cycles one requester keeps the grant; legal range 1..16.
- CNT_W, 4, width of the hold counter; must satisfy 2**CNT_W >= MAX_HOLD.

Ports:
- clk  input  1  single system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset; reset is asynchronous and active-low.
- req  input  8  request vector; bit i high = requester i wants the decoder.
- grant_idx  output  3  registered select index to the decoder (in[2:0]).
- grant_en  output  1  registered decoder enable; high while a grant is active.
- grant_onehot  output  8  combinational decode of grant_idx, gated by grant_en; equals 0 when grant_en is 0.
- busy  output  1  high whenever state is not IDLE.

Behaviour:
- States: IDLE, GRANT, GAP (GAP exists only with ARB_TURNAROUND_EN).
- Reset values (async, rst_n=0):
  - state=IDLE, grant_idx=0, grant_en=0, grant_onehot=0, busy=0, hold_cnt=0.
  - last_idx=7, so the first search starts at requester 0.
- Priority search: start at last_idx+1, wrap modulo 8; the first set req bit wins. The search is combinational on current req.
- IDLE, req==0: stay in IDLE.
- IDLE, req!=0: next edge goes to GRANT with grant_idx=winner, grant_en=1, hold_cnt=0, last_idx=winner. Latency from req sampled to grant_en high is 1 cycle.
- GRANT, each cycle:
  - Release when req[grant_idx]==0 OR hold_cnt==MAX_HOLD-1; otherwise hold_cnt increments.
  - Release without ARB_TURNAROUND_EN:
    - Search from grant_idx+1 using current req.
    - If a winner exists, switch directly to it: grant_en stays 1, grant_idx=new winner, hold_cnt=0, last_idx updated.
    - If no winner exists, go to IDLE with grant_en=0.
  - The search includes the current owner at lowest priority. A timed-out owner that is the sole requester is re-granted immediately with hold_cnt=0.
- Dropped request: the cycle req[grant_idx] is seen low is the last grant cycle. grant_en/grant_idx change on the following edge.
- Drop coinciding with timeout: treated as a single release, with no double arbitration.
- grant_idx holds its last value while grant_en=0. It is never forced to 0 except by reset.
- Requests are level-sensitive with no latching: a pulse shorter than one cycle between samples is lost.
- Reset mid-grant: outputs drop to reset values immediately (asynchronous). The first search after reset release starts at 0.
- MAX_HOLD=1: every grant lasts exactly 1 cycle, giving pure rotation under full load.

Optional Feature:
- Macro: ARB_TURNAROUND_EN.
- When defined, every release from GRANT goes to GAP for exactly 1 cycle with grant_en=0 and grant_onehot=0. This gives a dead cycle between chip selects.
- In GAP, the search runs from last_idx+1 on that cycle's req:
  - winner present: go to GRANT;
  - no winner: go to IDLE.
- busy=1 in GAP.
- When undefined: no GAP state; behaviour is exactly as described under Behaviour.

Test Plan:
- Reset then req=8'h00 for 5 cycles -> grant_en=0, grant_onehot=8'h00, busy=0 throughout.
- req=8'h04 held, MAX_HOLD=4:
  - grant_en rises 1 cycle later with grant_idx=2, grant_onehot=8'h04;
  - after 4 cycles it re-grants idx 2, with grant_en continuously 1 (turnaround off).
- req=8'hFF held, MAX_HOLD=1 -> grant_idx sequence 0,1,2,...,7,0 on consecutive cycles; grant_onehot walks 8'h01..8'h80.
- Owner idx 3 drops req after 2 cycles while req[6] and req[1] are high -> next grant_idx=6 (search from 4), then after 6 releases grant_idx=1.
- ARB_TURNAROUND_EN defined, req=8'h81 held, MAX_HOLD=2 -> pattern is idx0 x2, gap x1 (grant_en=0), idx7 x2, gap x1, idx0 x2 ...
- Assert rst_n=0 mid-grant on idx 5 -> grant_en and busy fall without waiting for clk. After release with req=8'h21, the first grant is idx 0.
